imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader_pkg.sv | 18 +
 rtl/imem_boot_loader_if.sv | 37 +++
 rtl/imem_boot_loader_port_mux.sv | 14 +
 rtl/imem_boot_loader.sv | 122 ++++++++++++
 tb/tb_imem_boot_loader.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
// Holds the loader state encoding and word-to-byte address mapping.
package imem_boot_loader_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_RUN
   } state_t;

   function automatic logic [31:0] imem_addr(input logic [29:0] widx);
      return {widx, 2'b00};
   endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Bundle of the boot loader's streaming input, memory port and status.
// master drives the upstream stream and PC; slave is the loader.
interface imem_boot_loader_if
   import imem_boot_loader_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH) + 2
);

   logic                  start;
   logic [$clog2(DEPTH):0] load_len;
   logic                  in_valid;
   logic [WORD_W-1:0]     in_data;
   logic                  in_ready;
   logic [AW-1:0]         pc;
   logic [AW-1:0]         mem_addr;
   logic                  mem_we;
   logic [WORD_W-1:0]     mem_wdata;
   logic                  cpu_rst;
   logic                  busy;
   logic                  done;
   logic                  len_err;
   logic [WORD_W-1:0]     checksum;

   modport master (
      output start, load_len, in_valid, in_data, pc,
      input  in_ready, mem_addr, mem_we, mem_wdata,
      input  cpu_rst, busy, done, len_err, checksum
   );

   modport slave (
      input  start, load_len, in_valid, in_data, pc,
      output in_ready, mem_addr, mem_we, mem_wdata,
      output cpu_rst, busy, done, len_err, checksum
   );

endinterface

// File: rtl/imem_boot_loader_port_mux.sv
// Instruction-memory A-port address select.
// The core PC owns the port while running; the loader owns it otherwise.
module imem_port_mux #(
   parameter int AW = 10
) (
   input  logic          i_run,
   input  logic [AW-1:0] i_pc,
   input  logic [AW-1:0] i_ld_addr,
   output logic [AW-1:0] o_addr
);

   assign o_addr = i_run ? i_pc : i_ld_addr;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams words into instruction memory, holding the core
// in reset until the session completes, then hands the port to the PC.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH) + 2
) (
   input  logic              clk,
   input  logic              rst,
   imem_boot_loader_if.slave bus
);

   localparam int IW = $clog2(DEPTH);
   localparam int LW = IW + 1;

   state_t            r_state;
   state_t            w_next;
   logic [LW-1:0]     r_len;
   logic [LW-1:0]     r_cnt;
   logic [IW-1:0]     r_wr_idx;
   logic              r_we;
   logic [WORD_W-1:0] r_wdata;
   logic [WORD_W-1:0] r_csum;
   logic              r_done;
   logic              r_len_err;

   logic              w_start_ok;
   logic              w_in_ready;
   logic              w_xfer;
   logic              w_last;
   logic              w_len_over;
   logic              w_len_zero;
   logic [LW-1:0]     w_len_clamp;
   logic [AW-1:0]     w_ld_addr;
   logic              w_run;

   assign w_len_over  = bus.load_len > LW'(DEPTH);
   assign w_len_zero  = bus.load_len == '0;
   assign w_len_clamp = w_len_over ? LW'(DEPTH) : bus.load_len;
   assign w_last      = r_cnt == (r_len - LW'(1));
   assign w_xfer      = w_in_ready && bus.in_valid;
   assign w_run       = r_state == S_RUN;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_in_ready = 1'b0;
      w_start_ok = 1'b0;
      unique case (r_state)
         S_IDLE, S_RUN: begin
            w_start_ok = bus.start;
            if (bus.start) w_next = w_len_zero ? S_RUN : S_LOAD;
         end
         S_LOAD: begin
            w_in_ready = 1'b1;
            if (bus.in_valid && w_last) w_next = S_FLUSH;
         end
         S_FLUSH: w_next = S_RUN;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_len     <= '0;
         r_cnt     <= '0;
         r_wr_idx  <= '0;
         r_we      <= 1'b0;
         r_wdata   <= '0;
         r_csum    <= '0;
         r_done    <= 1'b0;
         r_len_err <= 1'b0;
      end else begin
         r_we <= w_xfer;
         // Write is registered: address/data land one cycle after handshake
         if (w_xfer) begin
            r_wdata  <= bus.in_data;
            r_wr_idx <= r_cnt[IW-1:0];
            r_cnt    <= r_cnt + LW'(1);
            r_csum   <= r_csum ^ bus.in_data;
         end
         if (w_start_ok) begin
            r_len_err <= w_len_over;
            if (w_len_zero) begin
               r_done <= 1'b1;
            end else begin
               r_len    <= w_len_clamp;
               r_cnt    <= '0;
               r_wr_idx <= '0;
               r_csum   <= '0;
               r_done   <= 1'b0;
            end
         end else if (r_state == S_FLUSH) begin
            r_done <= 1'b1;
         end
      end
   end

   assign w_ld_addr = AW'(imem_addr(30'(r_wr_idx)));

   imem_port_mux #(.AW(AW)) u_mux (
      .i_run     (w_run),
      .i_pc      (bus.pc),
      .i_ld_addr (w_ld_addr),
      .o_addr    (bus.mem_addr)
   );

   assign bus.in_ready  = w_in_ready;
   assign bus.mem_we    = r_we;
   assign bus.mem_wdata = r_wdata;
   assign bus.cpu_rst   = !w_run;
   assign bus.busy      = (r_state == S_LOAD) || (r_state == S_FLUSH);
   assign bus.done      = r_done;
   assign bus.len_err   = r_len_err;
   assign bus.checksum  = r_csum;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued at
// stimulus time and popped by a monitor whenever mem_we is seen.
module tb_imem_boot_loader;

   localparam int DEPTH = 256;
   localparam int AW    = $clog2(DEPTH) + 2;

   typedef struct {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   n_writes;
   wr_t  exp_q[$];

   imem_boot_loader_if #(.DEPTH(DEPTH)) bus ();

   imem_boot_loader #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%h required=none",
                     bus.mem_addr);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(bus.mem_addr), 32'(e.a));
            check("wr_data", bus.mem_wdata, e.d);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int len);
      bus.start    = 1'b1;
      bus.load_len = 9'(len);
      tick();
      bus.start = 1'b0;
   endtask

   task automatic send(input int idx, input logic [31:0] w, input bit gap);
      wr_t e;
      e.a = AW'(idx * 4);
      e.d = w;
      exp_q.push_back(e);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      tick();
      bus.in_valid = 1'b0;
      if (gap) tick();
   endtask

   task automatic wait_run(input int max);
      int n;
      n = 0;
      while (bus.cpu_rst !== 1'b0 && n < max) begin
         tick();
         n++;
      end
      check("reach_run", 32'(bus.cpu_rst), 32'd0);
   endtask

   logic [31:0] prog [4];
   logic [31:0] x;
   int          w0;

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      checks       = 0;
      errors       = 0;
      n_writes     = 0;
      prog[0]      = 32'h00500093;
      prog[1]      = 32'h00100113;
      prog[2]      = 32'h002081B3;
      prog[3]      = 32'h00000063;
      bus.start    = 1'b0;
      bus.load_len = '0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.pc       = '0;
      rst          = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_csum", bus.checksum, 32'd0);
      check("rst_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      tick();

      // contiguous load of four words
      w0 = n_writes;
      do_start(4);
      check("load_busy", 32'(bus.busy), 32'd1);
      check("load_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 4; i++) send(i, prog[i], 1'b0);
      check("flush_ready", 32'(bus.in_ready), 32'd0);
      check("flush_busy", 32'(bus.busy), 32'd1);
      wait_run(10);
      check("run_done", 32'(bus.done), 32'd1);
      check("run_busy", 32'(bus.busy), 32'd0);
      check("run_csum", bus.checksum, 32'h00608050);
      check("nwr_contig", 32'(n_writes - w0), 32'd4);
      bus.pc = AW'(16);
      #1;
      check("run_pc_mux", 32'(bus.mem_addr), 32'h10);

      // re-program from RUN with gapped valid
      w0 = n_writes;
      do_start(4);
      check("reprog_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      check("reprog_done", 32'(bus.done), 32'd0);
      check("reprog_csum", bus.checksum, 32'd0);
      for (int i = 0; i < 4; i++) send(i, prog[i], 1'b1);
      wait_run(10);
      check("gap_csum", bus.checksum, 32'h00608050);
      check("nwr_gap", 32'(n_writes - w0), 32'd4);

      // oversize length clamps to DEPTH
      w0 = n_writes;
      x  = '0;
      do_start(300);
      check("len_err_set", 32'(bus.len_err), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         logic [31:0] w;
         w = (32'(i) * 32'h01010101) ^ 32'hA5000000;
         x = x ^ w;
         send(i, w, 1'b0);
      end
      wait_run(10);
      check("clamp_nwr", 32'(n_writes - w0), 32'(DEPTH));
      check("clamp_csum", bus.checksum, x);
      check("clamp_len_err", 32'(bus.len_err), 32'd1);
      check("clamp_ready", 32'(bus.in_ready), 32'd0);

      // zero-length start while running
      w0 = n_writes;
      do_start(0);
      check("zero_cpu_rst", 32'(bus.cpu_rst), 32'd0);
      check("zero_done", 32'(bus.done), 32'd1);
      check("zero_busy", 32'(bus.busy), 32'd0);
      check("zero_len_err", 32'(bus.len_err), 32'd0);
      tick();
      check("zero_nwr", 32'(n_writes - w0), 32'd0);

      // reset in the middle of a session
      w0 = n_writes;
      do_start(4);
      send(0, prog[0], 1'b0);
      send(1, prog[1], 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_ready", 32'(bus.in_ready), 32'd0);
      check("abort_addr_lsb", 32'(bus.mem_addr[1:0]), 32'd0);
      repeat (4) tick();
      check("abort_nwr", 32'(n_writes - w0), 32'd2);
      check("abort_idle", 32'(bus.cpu_rst), 32'd1);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
